// File: rtl/frost32_mem_arbiter.sv
// frost32_mem_arbiter
//   Shares the single Frost32 main-memory port between instruction fetch and
//   load/store data access. One transaction is in flight at a time and walks
//   IDLE -> ISSUE -> WAIT -> RESP. Read data is zero-extended by access size.
//
//   Optional build macro: FROST32_MEM_ARB_ALIGN_CHECK_EN
//     When defined, a misaligned data access is not sent to memory. It goes
//     straight from IDLE to RESP and completes with data_err = 1 and
//     data_rdata = 0. Fetch addresses are never checked.
//     When undefined, data_err is tied low and every access is forwarded.

module frost32_mem_arbiter #(
  parameter int unsigned MEM_LATENCY  = 1,  // 1..15
  parameter int unsigned STARVE_LIMIT = 4   // 1..15
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ack,
  output logic [31:0] fetch_rdata,

  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic        data_access_type,
  input  logic [1:0]  data_access_size,
  output logic        data_ack,
  output logic [31:0] data_rdata,
  output logic        data_err,

  output logic        busy,

  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_access_type,
  output logic [1:0]  mem_access_size,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  localparam logic [3:0] LAT   = 4'(MEM_LATENCY);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      r_state;
  owner_t      r_owner;
  logic [3:0]  r_lat_cnt;
  logic [3:0]  r_starve_cnt;
  logic        r_busy;
  logic        r_fetch_ack;
  logic        r_data_ack;
  logic [31:0] r_fetch_rdata;
  logic [31:0] r_data_rdata;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_mem_access_type;
  logic [1:0]  r_mem_access_size;

  logic        w_grant_fetch;
  logic        w_grant_data;
  logic        w_misaligned;
  logic        w_err_grant;
  logic [31:0] w_rdata_zext;

  // Fetch wins when it is alone, or when data has starved it for LIMIT grants.
  assign w_grant_fetch = fetch_req && (!data_req || (r_starve_cnt == LIMIT));
  assign w_grant_data  = data_req && !w_grant_fetch;

`ifdef FROST32_MEM_ARB_ALIGN_CHECK_EN
  assign w_misaligned = ((data_access_size == 2'd1) && data_addr[0]) ||
                        (data_access_size[1] && (data_addr[1:0] != 2'b00));
`else
  assign w_misaligned = 1'b0;
`endif

  // A misaligned data grant bypasses the memory bus entirely.
  assign w_err_grant = (r_state == ST_IDLE) && w_grant_data && w_misaligned;

  // Zero-extend the returned word according to the latched size code.
  always_comb begin
    w_rdata_zext = mem_rdata;
    case (r_mem_access_size)
      2'd0:    w_rdata_zext = {24'b0, mem_rdata[7:0]};
      2'd1:    w_rdata_zext = {16'b0, mem_rdata[15:0]};
      default: w_rdata_zext = mem_rdata;
    endcase
  end

  // Arbitration, transaction sequencing and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state           <= ST_IDLE;
      r_owner           <= OWN_FETCH;
      r_lat_cnt         <= 4'd0;
      r_starve_cnt      <= 4'd0;
      r_busy            <= 1'b0;
      r_fetch_ack       <= 1'b0;
      r_data_ack        <= 1'b0;
      r_fetch_rdata     <= 32'd0;
      r_data_rdata      <= 32'd0;
      r_mem_req         <= 1'b0;
      r_mem_addr        <= 32'd0;
      r_mem_wdata       <= 32'd0;
      r_mem_access_type <= 1'b0;
      r_mem_access_size <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments throughout; the strobes below default low
      // every cycle and are raised only on the edge that enters their state,
      // which makes them exact one-cycle pulses without extra clear logic.
      r_mem_req   <= 1'b0;
      r_fetch_ack <= 1'b0;
      r_data_ack  <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (!fetch_req || w_grant_fetch) begin
            r_starve_cnt <= 4'd0;
          end else if (w_grant_data && (r_starve_cnt != LIMIT)) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
          end

          if (w_grant_fetch || w_grant_data) begin
            r_busy            <= 1'b1;
            r_owner           <= w_grant_fetch ? OWN_FETCH : OWN_DATA;
            r_mem_addr        <= w_grant_fetch ? fetch_addr : data_addr;
            r_mem_wdata       <= w_grant_fetch ? 32'd0 : data_wdata;
            r_mem_access_type <= w_grant_fetch ? 1'b0 : data_access_type;
            r_mem_access_size <= w_grant_fetch ? 2'd2 : data_access_size;
            if (w_err_grant) begin
              r_state      <= ST_RESP;
              r_data_ack   <= 1'b1;
              r_data_rdata <= 32'd0;
            end else begin
              r_state   <= ST_ISSUE;
              r_mem_req <= 1'b1;
            end
          end
        end

        ST_ISSUE: begin
          r_lat_cnt <= LAT;
          r_state   <= ST_WAIT;
        end

        ST_WAIT: begin
          r_lat_cnt <= r_lat_cnt - 4'd1;
          if (r_lat_cnt == 4'd1) begin
            r_state <= ST_RESP;
            if (r_owner == OWN_FETCH) begin
              r_fetch_ack <= 1'b1;
              if (!r_mem_access_type) r_fetch_rdata <= w_rdata_zext;
            end else begin
              r_data_ack <= 1'b1;
              if (!r_mem_access_type) r_data_rdata <= w_rdata_zext;
            end
          end
        end

        ST_RESP: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef FROST32_MEM_ARB_ALIGN_CHECK_EN
  logic r_data_err;

  // Error flag pulses together with the data_ack of a misaligned access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_data_err <= 1'b0;
    else     r_data_err <= w_err_grant;
  end

  assign data_err = r_data_err;
`else
  assign data_err = 1'b0;
`endif

  assign busy            = r_busy;
  assign fetch_ack       = r_fetch_ack;
  assign fetch_rdata     = r_fetch_rdata;
  assign data_ack        = r_data_ack;
  assign data_rdata      = r_data_rdata;
  assign mem_req         = r_mem_req;
  assign mem_addr        = r_mem_addr;
  assign mem_wdata       = r_mem_wdata;
  assign mem_access_type = r_mem_access_type;
  assign mem_access_size = r_mem_access_size;

endmodule

// File: tb/tb_frost32_mem_arbiter.sv
// tb_frost32_mem_arbiter
//   Directed bench for frost32_mem_arbiter. Instance u_dut uses MEM_LATENCY=1,
//   STARVE_LIMIT=4; instance u_dut_b uses MEM_LATENCY=4 for the reset-abort case.
//   Expected completions are queued when a request is driven and popped on ack.

module tb_frost32_mem_arbiter;

  localparam int STARVE = 4;

  typedef struct {
    logic        is_fetch;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, rst_b;
  logic        fetch_req, data_req, b_fetch_req, b_data_req;
  logic [31:0] fetch_addr, data_addr, data_wdata, mem_rdata;
  logic        data_access_type;
  logic [1:0]  data_access_size;

  logic        fetch_ack, data_ack, data_err, busy, mem_req, mem_access_type;
  logic [31:0] fetch_rdata, data_rdata, mem_addr, mem_wdata;
  logic [1:0]  mem_access_size;

  logic        b_fetch_ack, b_data_ack, b_data_err, b_busy, b_mem_req, b_mem_access_type;
  logic [31:0] b_fetch_rdata, b_data_rdata, b_mem_addr, b_mem_wdata;
  logic [1:0]  b_mem_access_size;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  frost32_mem_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(STARVE)) u_dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .fetch_rdata(fetch_rdata),
    .data_req(data_req), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_access_type(data_access_type), .data_access_size(data_access_size),
    .data_ack(data_ack), .data_rdata(data_rdata), .data_err(data_err),
    .busy(busy),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_access_type(mem_access_type), .mem_access_size(mem_access_size),
    .mem_rdata(mem_rdata)
  );

  frost32_mem_arbiter #(.MEM_LATENCY(4), .STARVE_LIMIT(STARVE)) u_dut_b (
    .clk(clk), .rst(rst_b),
    .fetch_req(b_fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(b_fetch_ack), .fetch_rdata(b_fetch_rdata),
    .data_req(b_data_req), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_access_type(data_access_type), .data_access_size(data_access_size),
    .data_ack(b_data_ack), .data_rdata(b_data_rdata), .data_err(b_data_err),
    .busy(b_busy),
    .mem_req(b_mem_req), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_access_type(b_mem_access_type), .mem_access_size(b_mem_access_size),
    .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one request on u_dut, follow it to its ack and one cycle beyond.
  task automatic run_txn(input string tag, input logic is_fetch,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic wr, input logic [1:0] size,
                         input logic [31:0] mrd, input logic [31:0] exp_rd,
                         input logic exp_err, input int exp_lat, input int exp_memreq);
    exp_t e;
    int   n_memreq = 0;
    bit   got = 1'b0;
    @(negedge clk);
    mem_rdata = mrd;
    if (is_fetch) begin
      fetch_req  = 1'b1;
      fetch_addr = addr;
    end else begin
      data_req         = 1'b1;
      data_addr        = addr;
      data_wdata       = wdata;
      data_access_type = wr;
      data_access_size = size;
    end
    e.is_fetch = is_fetch;
    e.rdata    = exp_rd;
    e.err      = exp_err;
    sb_q.push_back(e);

    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (mem_req) begin
        n_memreq++;
        check({tag, ".mem_addr"}, mem_addr, addr);
        check({tag, ".mem_type"}, 32'(mem_access_type), is_fetch ? 32'd0 : 32'(wr));
        check({tag, ".mem_size"}, 32'(mem_access_size), is_fetch ? 32'd2 : 32'(size));
        check({tag, ".busy_issue"}, 32'(busy), 32'd1);
        if (!is_fetch && wr) check({tag, ".mem_wdata"}, mem_wdata, wdata);
      end
      if (fetch_ack || data_ack) begin
        got = 1'b1;
        check({tag, ".latency"}, 32'(k), 32'(exp_lat));
        e = sb_q.pop_front();
        check({tag, ".fetch_ack"}, 32'(fetch_ack), 32'(e.is_fetch));
        check({tag, ".data_ack"}, 32'(data_ack), 32'(!e.is_fetch));
        if (e.is_fetch) begin
          check({tag, ".fetch_rdata"}, fetch_rdata, e.rdata);
        end else begin
          check({tag, ".data_rdata"}, data_rdata, e.rdata);
          check({tag, ".data_err"}, 32'(data_err), 32'(e.err));
        end
        fetch_req = 1'b0;
        data_req  = 1'b0;
      end
    end
    check({tag, ".ack_seen"}, 32'(got), 32'd1);
    check({tag, ".mem_req_count"}, 32'(n_memreq), 32'(exp_memreq));
    if (!got) begin
      fetch_req = 1'b0;
      data_req  = 1'b0;
      sb_q.delete();
    end
    @(negedge clk);
    check({tag, ".ack_pulse"}, {30'd0, fetch_ack, data_ack}, 32'd0);
    check({tag, ".busy_idle"}, 32'(busy), 32'd0);
    if (is_fetch) check({tag, ".fetch_rdata_hold"}, fetch_rdata, exp_rd);
    else          check({tag, ".data_rdata_hold"}, data_rdata, exp_rd);
  endtask

  initial begin
    exp_t       e;
    int         acks;
    int         last_ack;
    int         sc;
    logic [3:0] cnt;
    logic       any_ack;
    bit         got;

    rst = 1'b1; rst_b = 1'b1;
    fetch_req = 1'b0; data_req = 1'b0; b_fetch_req = 1'b0; b_data_req = 1'b0;
    fetch_addr = '0; data_addr = '0; data_wdata = '0; mem_rdata = '0;
    data_access_type = 1'b0; data_access_size = 2'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.mem_req", 32'(mem_req), 32'd0);
    check("rst.mem_addr", mem_addr, 32'd0);
    check("rst.acks", {29'd0, fetch_ack, data_ack, data_err}, 32'd0);
    check("rst.fetch_rdata", fetch_rdata, 32'd0);
    check("rst.data_rdata", data_rdata, 32'd0);
    rst = 1'b0; rst_b = 1'b0;

    // Single-requester transactions, MEM_LATENCY = 1
    run_txn("fetch",   1'b1, 32'h0000_0100, 32'd0, 1'b0, 2'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 3, 1);
    run_txn("rd_byte", 1'b0, 32'h0000_0203, 32'd0, 1'b0, 2'd0, 32'h1234_56A5, 32'h0000_00A5, 1'b0, 3, 1);
    run_txn("rd_half", 1'b0, 32'h0000_0202, 32'd0, 1'b0, 2'd1, 32'h1234_ABCD, 32'h0000_ABCD, 1'b0, 3, 1);
    run_txn("wr_word", 1'b0, 32'h0000_0040, 32'hCAFE_F00D, 1'b1, 2'd2, 32'h7777_7777, 32'h0000_ABCD, 1'b0, 3, 1);
    run_txn("rd_sz3",  1'b0, 32'h0000_0080, 32'd0, 1'b0, 2'd3, 32'h89AB_CDEF, 32'h89AB_CDEF, 1'b0, 3, 1);
    run_txn("fetch_unaligned", 1'b1, 32'h0000_0102, 32'd0, 1'b0, 2'd2, 32'h0F0F_1234, 32'h0F0F_1234, 1'b0, 3, 1);

    // Both requesters held: expected grant order from the starvation model
    @(negedge clk);
    cnt = 4'd0;
    for (int i = 0; i < 10; i++) begin
      e.is_fetch = (cnt == 4'(STARVE));
      e.rdata    = 32'h0BAD_F00D;
      e.err      = 1'b0;
      sb_q.push_back(e);
      if (e.is_fetch) cnt = 4'd0;
      else            cnt = cnt + 4'd1;
    end
    fetch_addr = 32'h0000_0300; data_addr = 32'h0000_0500;
    data_access_type = 1'b0; data_access_size = 2'd2;
    mem_rdata = 32'h0BAD_F00D;
    fetch_req = 1'b1; data_req = 1'b1;
    acks = 0; last_ack = -1;
    for (int c = 1; c <= 200 && acks < 10; c++) begin
      @(negedge clk);
      if (mem_req && sb_q.size() > 0)
        check("starve.mem_addr", mem_addr, sb_q[0].is_fetch ? 32'h0000_0300 : 32'h0000_0500);
      if (fetch_ack || data_ack) begin
        check("starve.overlap", 32'(fetch_ack & data_ack), 32'd0);
        check("starve.busy", 32'(busy), 32'd1);
        if (last_ack >= 0) check("starve.spacing", 32'(c - last_ack), 32'd4);
        last_ack = c;
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("starve.owner", 32'(fetch_ack), 32'(e.is_fetch));
          check("starve.rdata", e.is_fetch ? fetch_rdata : data_rdata, e.rdata);
        end
        acks++;
        if (acks == 10) begin
          fetch_req = 1'b0;
          data_req  = 1'b0;
        end
      end
    end
    check("starve.ack_count", 32'(acks), 32'd10);
    fetch_req = 1'b0; data_req = 1'b0;
    sb_q.delete();
    repeat (2) @(negedge clk);

    // Misaligned data access
`ifdef FROST32_MEM_ARB_ALIGN_CHECK_EN
    run_txn("misaligned", 1'b0, 32'h0000_0042, 32'd0, 1'b0, 2'd2, 32'h2468_ACE0, 32'h0000_0000, 1'b1, 1, 0);
`else
    run_txn("misaligned", 1'b0, 32'h0000_0042, 32'd0, 1'b0, 2'd2, 32'h2468_ACE0, 32'h2468_ACE0, 1'b0, 3, 1);
`endif
    run_txn("aligned_after", 1'b0, 32'h0000_0044, 32'd0, 1'b0, 2'd2, 32'h1357_9BDF, 32'h1357_9BDF, 1'b0, 3, 1);

    // Reset during WAIT on the MEM_LATENCY = 4 instance
    @(negedge clk);
    data_addr = 32'h0000_0600; data_access_type = 1'b0; data_access_size = 2'd2;
    mem_rdata = 32'h1122_3344;
    b_data_req = 1'b1;
    repeat (3) @(negedge clk);
    check("abort.busy_before", 32'(b_busy), 32'd1);
    check("abort.addr_before", b_mem_addr, 32'h0000_0600);
    rst_b = 1'b1;
    #1;
    check("abort.busy", 32'(b_busy), 32'd0);
    check("abort.mem_addr", b_mem_addr, 32'd0);
    check("abort.mem_size", 32'(b_mem_access_size), 32'd0);
    check("abort.strobes", {29'd0, b_mem_req, b_data_ack, b_fetch_ack}, 32'd0);
    @(negedge clk);
    b_data_req = 1'b0;
    rst_b = 1'b0;
    any_ack = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      any_ack = any_ack | b_data_ack | b_fetch_ack;
    end
    check("abort.no_ack", 32'(any_ack), 32'd0);

    // Normal service after the abort: ack at 2 + MEM_LATENCY
    data_addr = 32'h0000_0604; mem_rdata = 32'h5566_7788;
    b_data_req = 1'b1;
    got = 1'b0; sc = 0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (b_mem_req) check("post_abort.mem_addr", b_mem_addr, 32'h0000_0604);
      if (b_data_ack) begin
        got = 1'b1;
        sc  = k;
        b_data_req = 1'b0;
      end
    end
    check("post_abort.latency", 32'(sc), 32'd6);
    check("post_abort.rdata", b_data_rdata, 32'h5566_7788);
    check("post_abort.err", 32'(b_data_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
